// File: rtl/tt_um_emern_update_sched.sv
// Frame-atomic update scheduler: queues register writes in groups and drains one
// complete group per vertical-blanking pulse. Optional macro: UPDATE_SCHED_COMMIT_CNT_EN.
module tt_um_emern_update_sched #(
    parameter int WADDR = 5,
    parameter int WDATA = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [WADDR-1:0]           wr_addr,
    input  logic [WDATA-1:0]           wr_data,
    input  logic                       wr_last,
    input  logic                       vblank_start,
    output logic                       reg_we,
    output logic [WADDR-1:0]           reg_addr,
    output logic [WDATA-1:0]           reg_data,
    output logic                       busy,
    output logic                       group_done,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       overflow_err,
    input  logic                       err_clr,
    output logic [7:0]                 commit_cnt
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + WADDR + WDATA;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic [PW-1:0]    pending_q, pending_d;
    logic [0:0]       state_q, state_d;
    logic             err_q, err_d;
    logic             reg_we_q, busy_q, group_done_q;
    logic [WADDR-1:0] reg_addr_q;
    logic [WDATA-1:0] reg_data_q;

    logic             full, push, pop, flush, head_last;
    logic [EW-1:0]    head;

    assign full      = (count_q == PW'(DEPTH));
    assign wr_ready  = !full;
    // A full FIFO without any closing entry can never drain: discard it.
    assign flush     = full && (pending_q == '0);
    assign push      = wr_valid && !full;
    assign pop       = (state_q == S_DRAIN) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign head_last = head[EW-1];

    always_comb begin
        count_d   = count_q + PW'(push) - PW'(pop);
        pending_d = pending_q + PW'(push && wr_last) - PW'(pop && head_last);
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        state_d   = state_q;
        err_d     = err_clr ? 1'b0 : err_q;
        case (state_q)
            S_IDLE:  if (vblank_start && (pending_q != '0)) state_d = S_DRAIN;
            S_DRAIN: if (pop && head_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            count_d   = '0;
            pending_d = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            state_d   = S_IDLE;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_last, wr_addr, wr_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            pending_q    <= '0;
            state_q      <= S_IDLE;
            err_q        <= 1'b0;
            reg_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            group_done_q <= 1'b0;
            reg_addr_q   <= '0;
            reg_data_q   <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            state_q      <= state_d;
            err_q        <= err_d;
            reg_we_q     <= pop;
            busy_q       <= pop;
            group_done_q <= pop && head_last;
            if (pop) begin
                reg_addr_q <= head[WADDR+WDATA-1:WDATA];
                reg_data_q <= head[WDATA-1:0];
            end
        end
    end

`ifdef UPDATE_SCHED_COMMIT_CNT_EN
    logic [7:0] commit_q;
    always_ff @(posedge clk) begin
        if (rst) commit_q <= 8'd0;
        else if (pop && head_last) commit_q <= commit_q + 8'd1;
    end
    assign commit_cnt = commit_q;
`else
    assign commit_cnt = 8'd0;
`endif

    assign reg_we       = reg_we_q;
    assign reg_addr     = reg_addr_q;
    assign reg_data     = reg_data_q;
    assign busy         = busy_q;
    assign group_done   = group_done_q;
    assign pending      = pending_q;
    assign overflow_err = err_q;

endmodule
